// File: rtl/aes_round_sequencer.sv
// Drives EXEC through AES-128 key expansion and ten cipher rounds for one block at a time.
// Latency 21 cycles from acceptance (11 with key reuse); the result is held in DONE until out_ready.
module aes_round_sequencer #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  input  logic         in_encrypt,
  input  logic         in_reuse_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [127:0] exA,
  output logic [127:0] exB,
  output logic [127:0] exC,
  output logic [1:0]   exExecSrc,
  output logic         exKeyAssist,
  output logic         exEncryption,
  output logic         exFinalRound,
  input  logic [127:0] exResult
);

  localparam logic [3:0] LAST_RND = 4'(NROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         enc_q, enc_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] out_q, out_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    enc_d        = enc_q;
    key_valid_d  = key_valid_q;
    blk_d        = blk_q;
    out_d        = out_q;
    rk_d         = rk_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    exA          = '0;
    exB          = '0;
    exC          = '0;
    exExecSrc    = 2'd0;
    exKeyAssist  = 1'b0;
    exEncryption = 1'b0;
    exFinalRound = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = reset;
        if (in_valid) begin
          enc_d = in_encrypt;
          rnd_d = 4'd1;
          if (in_reuse_key && key_valid_q) begin
            blk_d   = in_block ^ (in_encrypt ? rk_q[0] : rk_q[10]);
            state_d = S_ROUND;
          end else begin
            rk_d[0]     = in_key;
            key_valid_d = 1'b0;
            blk_d       = in_block;
            state_d     = S_KEYEXP;
          end
        end
      end

      S_KEYEXP: begin
        busy        = 1'b1;
        exA         = rk_q[rnd_q - 4'd1];
        exC         = {120'd0, rcon(rnd_q)};
        exExecSrc   = 2'd2;
        exKeyAssist = 1'b1;
        rk_d[rnd_q] = exResult;
        if (rnd_q == LAST_RND) begin
          // Decrypt whitening needs rk[10], which is only being produced this cycle.
          key_valid_d = 1'b1;
          rnd_d       = 4'd1;
          blk_d       = blk_q ^ (enc_q ? rk_q[0] : exResult);
          state_d     = S_ROUND;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_ROUND: begin
        busy         = 1'b1;
        exA          = blk_q;
        exB          = enc_q ? rk_q[rnd_q] : rk_q[LAST_RND - rnd_q];
        exExecSrc    = 2'd2;
        exEncryption = enc_q;
        exFinalRound = (rnd_q == LAST_RND);
        blk_d        = exResult;
        if (rnd_q == LAST_RND) begin
          out_d   = exResult;
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rnd_q       <= 4'd0;
      enc_q       <= 1'b0;
      key_valid_q <= 1'b0;
      blk_q       <= '0;
      out_q       <= '0;
      for (int i = 0; i < 11; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      enc_q       <= enc_d;
      key_valid_q <= key_valid_d;
      blk_q       <= blk_d;
      out_q       <= out_d;
      rk_q        <= rk_d;
    end
  end

  assign out_block = out_q;

endmodule
